alu_operand_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the 16-bit ALU. It captures decoded operands and control each cycle. It drives the ALU's two operand inputs and 4-bit operation code, with RAW hazards resolved by forwarding from EX/MEM and MEM/WB. It also detects load-use hazards and inserts a bubble.

---
 rtl/alu_operand_stage.sv | 173 +++++++++++++++++
 tb/tb_alu_operand_stage.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use
// hazard detection, feeding the operand, opcode and control inputs of the 16-bit ALU.
module alu_operand_stage #(
  parameter int W   = 16,
  parameter int RW  = 3,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           flush,
  input  logic           id_valid,
  input  logic [RW-1:0]  id_rs1,
  input  logic [RW-1:0]  id_rs2,
  input  logic           id_use1,
  input  logic           id_use2,
  input  logic [W-1:0]   id_rd1_data,
  input  logic [W-1:0]   id_rd2_data,
  input  logic [W-1:0]   id_imm,
  input  logic           id_use_imm,
  input  logic [OPW-1:0] id_alu_op,
  input  logic [RW-1:0]  id_rd,
  input  logic           id_reg_write,
  input  logic           id_mem_read,
  input  logic           exm_reg_write,
  input  logic [RW-1:0]  exm_rd,
  input  logic [W-1:0]   exm_result,
  input  logic           wb_reg_write,
  input  logic [RW-1:0]  wb_rd,
  input  logic [W-1:0]   wb_data,
  output logic           ex_valid,
  output logic [W-1:0]   alu_in1,
  output logic [W-1:0]   alu_in2,
  output logic [OPW-1:0] alu_op,
  output logic [RW-1:0]  ex_rd,
  output logic           ex_reg_write,
  output logic           ex_mem_read,
  output logic           hazard_stall
);

  typedef struct packed {
    logic           valid;
    logic [RW-1:0]  rs1;
    logic [RW-1:0]  rs2;
    logic           use1;
    logic           use2;
    logic [W-1:0]   rd1_data;
    logic [W-1:0]   rd2_data;
    logic [W-1:0]   imm;
    logic           use_imm;
    logic [OPW-1:0] alu_op;
    logic [RW-1:0]  rd;
    logic           reg_write;
    logic           mem_read;
  } idex_t;

  typedef enum logic [1:0] {
    SRC_REG,
    SRC_EXM,
    SRC_WB,
    SRC_IMM
  } src_e;

  idex_t q;
  idex_t d;
  idex_t id_word;
  src_e  src1;
  src_e  src2;

  always_comb begin
    id_word = '{
      valid:     id_valid,
      rs1:       id_rs1,
      rs2:       id_rs2,
      use1:      id_use1,
      use2:      id_use2,
      rd1_data:  id_rd1_data,
      rd2_data:  id_rd2_data,
      imm:       id_imm,
      use_imm:   id_use_imm,
      alu_op:    id_alu_op,
      rd:        id_rd,
      reg_write: id_reg_write,
      mem_read:  id_mem_read
    };
  end

  // A load in EX whose destination feeds an operand ID actually reads.
  assign hazard_stall = q.valid & q.mem_read & id_valid &
                        ((id_use1 & (id_rs1 == q.rd)) |
                         (id_use2 & ~id_use_imm & (id_rs2 == q.rd)));

  // Flush beats stall, stall beats the hazard bubble.
  always_comb begin
    // NOTE: d gets a full default first so no path through this block can infer a latch.
    d = q;
    if (flush) begin
      d           = id_word;
      d.valid     = 1'b0;
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
    end else if (stall) begin
      d = q;
    end else if (hazard_stall) begin
      d           = id_word;
      d.valid     = 1'b0;
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
    end else begin
      d = id_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  // EX/MEM is checked first: it carries the younger result for the same register.
  always_comb begin
    src1 = SRC_REG;
    if (q.use1) begin
      if (exm_reg_write && (exm_rd == q.rs1)) begin
        src1 = SRC_EXM;
      end else if (wb_reg_write && (wb_rd == q.rs1)) begin
        src1 = SRC_WB;
      end
    end
  end

  always_comb begin
    src2 = SRC_REG;
    if (q.use_imm) begin
      src2 = SRC_IMM;
    end else if (q.use2) begin
      if (exm_reg_write && (exm_rd == q.rs2)) begin
        src2 = SRC_EXM;
      end else if (wb_reg_write && (wb_rd == q.rs2)) begin
        src2 = SRC_WB;
      end
    end
  end

  always_comb begin
    alu_in1 = q.rd1_data;
    case (src1)
      SRC_EXM: alu_in1 = exm_result;
      SRC_WB:  alu_in1 = wb_data;
      default: alu_in1 = q.rd1_data;
    endcase
  end

  always_comb begin
    alu_in2 = q.rd2_data;
    case (src2)
      SRC_EXM: alu_in2 = exm_result;
      SRC_WB:  alu_in2 = wb_data;
      SRC_IMM: alu_in2 = q.imm;
      default: alu_in2 = q.rd2_data;
    endcase
  end

  assign ex_valid     = q.valid;
  assign alu_op       = q.alu_op;
  assign ex_rd        = q.rd;
  assign ex_reg_write = q.valid & q.reg_write;
  assign ex_mem_read  = q.valid & q.mem_read;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and randomized bench for alu_operand_stage, checked against a
// behavioural model of the ID/EX contents and the forwarding rules.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [2:0]  id_rs1;
  logic [2:0]  id_rs2;
  logic        id_use1;
  logic        id_use2;
  logic [15:0] id_rd1_data;
  logic [15:0] id_rd2_data;
  logic [15:0] id_imm;
  logic        id_use_imm;
  logic [3:0]  id_alu_op;
  logic [2:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        exm_reg_write;
  logic [2:0]  exm_rd;
  logic [15:0] exm_result;
  logic        wb_reg_write;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        ex_valid;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [3:0]  alu_op;
  logic [2:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        hazard_stall;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2),
    .id_rd1_data(id_rd1_data), .id_rd2_data(id_rd2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_op(alu_op), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .hazard_stall(hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction held in the ALU stage; 'known' is cleared when
  // only the control bits are defined (after a flush or hazard bubble).
  typedef struct {
    bit valid;
    int rs1;
    int rs2;
    bit use1;
    bit use2;
    int d1;
    int d2;
    int imm;
    bit use_imm;
    int op;
    int rd;
    bit rw;
    bit mr;
  } instr_t;

  instr_t m;
  bit     m_known;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t id_now();
    instr_t i;
    i.valid   = id_valid;
    i.rs1     = int'(id_rs1);
    i.rs2     = int'(id_rs2);
    i.use1    = id_use1;
    i.use2    = id_use2;
    i.d1      = int'(id_rd1_data);
    i.d2      = int'(id_rd2_data);
    i.imm     = int'(id_imm);
    i.use_imm = id_use_imm;
    i.op      = int'(id_alu_op);
    i.rd      = int'(id_rd);
    i.rw      = id_reg_write;
    i.mr      = id_mem_read;
    return i;
  endfunction

  function automatic instr_t zero_instr();
    instr_t i;
    i = '{valid: 0, rs1: 0, rs2: 0, use1: 0, use2: 0, d1: 0, d2: 0, imm: 0,
          use_imm: 0, op: 0, rd: 0, rw: 0, mr: 0};
    return i;
  endfunction

  function automatic bit exp_hazard();
    return m.valid && m.mr && id_valid &&
           ((id_use1 && int'(id_rs1) == m.rd) ||
            (id_use2 && !id_use_imm && int'(id_rs2) == m.rd));
  endfunction

  // Newest producer first: EX/MEM, then MEM/WB, then the register-file value.
  function automatic int fwd(bit used, int rs, int data);
    if (!used) return data;
    if (exm_reg_write && int'(exm_rd) == rs) return int'(exm_result);
    if (wb_reg_write && int'(wb_rd) == rs) return int'(wb_data);
    return data;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".ex_valid"}, 32'(ex_valid), 32'(m.valid));
    check({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(m.valid && m.rw));
    check({tag, ".ex_mem_read"}, 32'(ex_mem_read), 32'(m.valid && m.mr));
    check({tag, ".hazard"}, 32'(hazard_stall), 32'(exp_hazard()));
    if (m_known) begin
      check({tag, ".alu_in1"}, 32'(alu_in1), fwd(m.use1, m.rs1, m.d1));
      check({tag, ".alu_in2"}, 32'(alu_in2),
            m.use_imm ? m.imm : fwd(m.use2, m.rs2, m.d2));
      check({tag, ".alu_op"}, 32'(alu_op), m.op);
      check({tag, ".ex_rd"}, 32'(ex_rd), m.rd);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".ex_valid"}, 32'(ex_valid), 0);
    check({tag, ".alu_in1"}, 32'(alu_in1), 0);
    check({tag, ".alu_in2"}, 32'(alu_in2), 0);
    check({tag, ".alu_op"}, 32'(alu_op), 0);
    check({tag, ".ex_rd"}, 32'(ex_rd), 0);
    check({tag, ".ex_reg_write"}, 32'(ex_reg_write), 0);
    check({tag, ".ex_mem_read"}, 32'(ex_mem_read), 0);
    check({tag, ".hazard"}, 32'(hazard_stall), 0);
  endtask

  // Advance one clock, updating the model with the inputs present before the edge.
  task automatic tick();
    instr_t n;
    bit     nk;
    if (flush) begin
      n = id_now(); n.valid = 0; n.rw = 0; n.mr = 0; nk = 0;
    end else if (stall) begin
      n = m; nk = m_known;
    end else if (exp_hazard()) begin
      n = id_now(); n.valid = 0; n.rw = 0; n.mr = 0; nk = 0;
    end else begin
      n = id_now(); nk = 1;
    end
    @(posedge clk);
    #1;
    m       = n;
    m_known = nk;
  endtask

  task automatic drive_id(input bit v, input int rs1, input int rs2, input bit u1,
                          input bit u2, input int d1, input int d2, input int imm,
                          input bit ui, input int op, input int rd, input bit rw,
                          input bit mr);
    id_valid     = v;
    id_rs1       = 3'(rs1);
    id_rs2       = 3'(rs2);
    id_use1      = u1;
    id_use2      = u2;
    id_rd1_data  = 16'(d1);
    id_rd2_data  = 16'(d2);
    id_imm       = 16'(imm);
    id_use_imm   = ui;
    id_alu_op    = 4'(op);
    id_rd        = 3'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic drive_fw(input bit erw, input int erd, input int eres,
                          input bit wrw, input int wrd, input int wd);
    exm_reg_write = erw;
    exm_rd        = 3'(erd);
    exm_result    = 16'(eres);
    wb_reg_write  = wrw;
    wb_rd         = 3'(wrd);
    wb_data       = 16'(wd);
  endtask

  initial begin
    m       = zero_instr();
    m_known = 1;
    rst     = 1'b1;
    stall   = 1'b0;
    flush   = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_fw(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");

    // Load, then assert reset asynchronously in the middle of the cycle.
    rst = 1'b0;
    drive_id(1, 1, 2, 1, 1, 11, 22, 0, 0, 5, 3, 1, 1);
    tick();
    check_all("pre_rst");
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    m       = zero_instr();
    m_known = 1;
    #1;
    rst = 1'b0;

    drive_id(1, 0, 0, 0, 0, 20, 30, 0, 0, 2, 1, 1, 0);
    tick();
    check("load.alu_in1", 32'(alu_in1), 20);
    check("load.alu_in2", 32'(alu_in2), 30);
    check("load.alu_op", 32'(alu_op), 2);
    check("load.ex_valid", 32'(ex_valid), 1);

    // EX/MEM forward on operand 1.
    drive_id(1, 3, 0, 1, 0, 5, 0, 0, 0, 1, 4, 1, 0);
    tick();
    drive_fw(1, 3, 'hFFFF, 0, 0, 0);
    #1;
    check("exm_fwd.alu_in1", 32'(alu_in1), 'hFFFF);
    check_all("exm_fwd");

    // Both stages match rs2: EX/MEM first, MEM/WB once EX/MEM stops writing.
    drive_fw(0, 0, 0, 0, 0, 0);
    drive_id(1, 0, 4, 0, 1, 0, 7, 0, 0, 3, 5, 1, 0);
    tick();
    drive_fw(1, 4, 10, 1, 4, 100);
    #1;
    check("double.alu_in2", 32'(alu_in2), 10);
    drive_fw(0, 4, 10, 1, 4, 100);
    #1;
    check("wb_fwd.alu_in2", 32'(alu_in2), 100);

    // Immediate operand ignores a matching producer.
    drive_id(1, 0, 5, 0, 1, 0, 9, 'hFFFE, 1, 4, 6, 1, 0);
    tick();
    drive_fw(1, 5, 'h1234, 1, 5, 55);
    #1;
    check("imm.alu_in2", 32'(alu_in2), 'hFFFE);
    check_all("imm");

    // Load-use: one stall cycle, one bubble, then the dependent instruction.
    drive_fw(0, 0, 0, 0, 0, 0);
    drive_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 8, 2, 1, 1);
    tick();
    drive_id(1, 2, 0, 1, 0, 77, 0, 0, 0, 7, 3, 1, 0);
    #1;
    check("lu.hazard", 32'(hazard_stall), 1);
    tick();
    check("lu.bubble_valid", 32'(ex_valid), 0);
    check("lu.bubble_rw", 32'(ex_reg_write), 0);
    check("lu.hazard_clear", 32'(hazard_stall), 0);
    tick();
    check("lu.dep_valid", 32'(ex_valid), 1);
    check("lu.dep_op", 32'(alu_op), 7);
    check_all("lu.dep");

    // Same pair but rs1 not read: no stall.
    drive_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 8, 2, 1, 1);
    tick();
    drive_id(1, 2, 0, 0, 0, 77, 0, 0, 0, 7, 3, 1, 0);
    #1;
    check("nolu.hazard", 32'(hazard_stall), 0);
    tick();
    check("nolu.valid", 32'(ex_valid), 1);
    check("nolu.op", 32'(alu_op), 7);

    // Stall holds the load, so the hazard stays asserted.
    drive_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 8, 2, 1, 1);
    tick();
    drive_id(1, 0, 2, 0, 1, 0, 0, 0, 0, 6, 3, 1, 0);
    stall = 1'b1;
    #1;
    check("sh.hazard0", 32'(hazard_stall), 1);
    tick();
    check("sh.hazard1", 32'(hazard_stall), 1);
    check("sh.mem_read", 32'(ex_mem_read), 1);
    stall = 1'b0;
    tick();
    check("sh.bubble", 32'(ex_valid), 0);

    // Three stall cycles hold everything; flush then wins over stall.
    drive_id(1, 1, 1, 0, 0, 41, 42, 0, 0, 9, 4, 1, 0);
    tick();
    stall = 1'b1;
    drive_id(1, 6, 6, 0, 0, 1, 2, 0, 0, 3, 5, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall.op", 32'(alu_op), 9);
      check("stall.in1", 32'(alu_in1), 41);
      check("stall.in2", 32'(alu_in2), 42);
      check("stall.valid", 32'(ex_valid), 1);
      tick();
    end
    check_all("stall.end");
    flush = 1'b1;
    tick();
    check("flush.valid", 32'(ex_valid), 0);
    check("flush.rw", 32'(ex_reg_write), 0);
    flush = 1'b0;
    stall = 1'b0;

    // Randomized traffic with small index space so matches are frequent.
    for (int c = 0; c < 400; c++) begin
      drive_id(1'($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 65535)), 1'($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom_range(0, 2) == 0));
      drive_fw(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
               1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
      stall = 1'($urandom_range(0, 7) == 0);
      flush = 1'($urandom_range(0, 9) == 0);
      #1;
      check_all("rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
